clk_gate_ctrl: RTL and testbench
================================

// Module: clk_gate_ctrl
//
// PURPOSE
//   Controller driving en_i of a downstream tc_clk_gating instance. Gates the clock automatically
//   after a programmable run of idle cycles and restores it on demand, with a settle delay.
//   Runs on the free-running (ungated) clock, between the power manager and one gated subsystem.
//   Requesters obtain a guaranteed-running clock through a four-phase req/ack handshake.
//
// PARAMETERS
//   IDLE_CNT_W   8   width of idle threshold and idle counter
//   WAKE_CYCLES  2   cycles clk_en_o is high before ack may assert; 0 = OFF goes straight to ON
//   RST_CLK_ON   1   1: leave reset in ON with clock enabled; 0: leave reset in OFF, gated
//   GATE_CNT_W   16  width of the saturating gate-off event counter
//
// PORTS
//   clk_i          in   1           free-running clock (never the gated clock)
//   rst_i          in   1           reset, synchronous, active-high
//   auto_gate_en_i in   1           1 = automatic gating allowed; 0 = clock held on
//   force_on_i     in   1           functional force-on; blocks gating, wakes from OFF
//   idle_thr_i     in   IDLE_CNT_W  idle cycles required before gating
//   busy_i         in   1           gated subsystem has outstanding work
//   req_i          in   1           four-phase clock request
//   ack_o          out  1           clock running and stable for the requester
//   clk_en_o       out  1           registered enable to the clock gate en_i
//   state_o        out  2           current FSM state (OFF=0, WAKE=1, ON=2, IDLE=3)
//   gate_cnt_o     out  GATE_CNT_W  number of ON->OFF transitions, saturating
//
// BEHAVIOUR
//   Reset (sync, rst_i=1 at edge): state = ON if RST_CLK_ON else OFF; clk_en_o = RST_CLK_ON;
//     ack_o = 0; idle, wake and gate counters = 0. Reset mid-WAKE or mid-IDLE aborts the sequence.
//   wake = req_i | busy_i | force_on_i | ~auto_gate_en_i.
//   OFF : clk_en_o = 0. If wake, go to WAKE, or to ON when WAKE_CYCLES == 0. Wake counter = 0.
//   WAKE: clk_en_o = 1. Wake counter increments each cycle.
//         At wake counter == WAKE_CYCLES-1, go to ON.
//         No abort path: WAKE always completes.
//   ON  : clk_en_o = 1. If ~wake, go to IDLE, idle counter = 0, latch idle_thr_i into thr_q.
//   IDLE: clk_en_o = 1. If wake, return to ON (counter discarded).
//         Else if idle counter == thr_q, go to OFF and increment gate_cnt_o (saturating at all-ones).
//         Else the idle counter increments.
//         thr_q is fixed for the whole IDLE episode; changes to idle_thr_i apply next episode.
//         thr_q = 0 means gating at the first IDLE cycle: clk_en_o low 2 cycles after the ON exit.
//   All outputs are registered and derived from next-state, so clk_en_o is glitch-free.
//   clk_en_o changes on clk_i rising edge only; the latch gate samples it while clk_i is low.
//   Handshake:
//     ack_o <= req_i & (next_state == ON).
//     The requester holds req_i until ack_o is seen, then drops it; ack_o falls on the next edge.
//     While req_i is high the FSM never leaves ON/WAKE, so ack_o is never retracted while req_i=1.
//   Latency:
//     req_i rise in ON -> ack_o after 1 cycle.
//     req_i rise in OFF -> ack_o after WAKE_CYCLES+1 cycles.
//     req_i rise in IDLE -> ack_o after 1 cycle (IDLE->ON).
//   Simultaneous events:
//     wake in the same cycle the idle count hits thr_q: wake wins, stay clocked (IDLE->ON).
//     Gate counter at saturation: holds at all-ones, no wrap.
//     A busy_i pulse in OFF wakes the clock; no ack_o without req_i.
//
// STRUCTURE
//   clk_gate_ctrl_pkg: typedef enum logic [1:0] {OFF, WAKE, ON, IDLE} cgc_state_e;
//     state_o encoding constants.
//   Single module, no sub-module.
//   One next-state/comb process, one registered process for state, counters, clk_en_o, ack_o.
//   The tc_clk_gating instance lives in the parent, fed by clk_en_o.
//
// TESTING
//   1 Reset, RST_CLK_ON=1, auto=1, thr=3, all idle
//       -> clk_en_o=1 for 1+4 cycles, then 0; state ON,IDLE,IDLE,IDLE,IDLE,OFF; gate_cnt_o=1.
//   2 In OFF, WAKE_CYCLES=2, pulse req_i
//       -> clk_en_o=1 next cycle; ack_o high 3 cycles after req_i; drop req_i -> ack_o low next cycle.
//   3 In IDLE with count=2, thr=3, assert busy_i -> return to ON, no gating.
//       Deassert busy_i -> count restarts from 0.
//   4 thr=0 -> ON->IDLE->OFF, gating 2 cycles after idle.
//       Change idle_thr_i mid-IDLE from 10 to 1 -> still gates after 10.
//   5 Wake and idle-count==thr in the same cycle -> stays clocked.
//       auto_gate_en_i=0 in OFF -> wakes, never regates.
//   6 Sync reset asserted mid-WAKE and mid-IDLE -> reset values next edge, ack_o=0.
//       Force gate_cnt to all-ones -> one more gating leaves it saturated.

Source files
------------

// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and constants for the clock-gate controller.
package clk_gate_ctrl_pkg;

    // FSM states; the encoding is also the externally visible state_o value.
    typedef enum logic [1:0] {
        OFF  = 2'd0,
        WAKE = 2'd1,
        ON   = 2'd2,
        IDLE = 2'd3
    } cgc_state_e;

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_WAKE = 2'd1;
    localparam logic [1:0] ST_ON   = 2'd2;
    localparam logic [1:0] ST_IDLE = 2'd3;

    // Every state except OFF drives the clock gate enable high.
    function automatic logic cgc_clocked(input cgc_state_e s);
        return (s != OFF);
    endfunction

endpackage

// File: rtl/clk_gate_ctrl.sv
// Idle-driven clock gate enable controller with a req/ack clock request
// handshake. Runs on the free-running clock; clk_en_o feeds the en input
// of a latch-based clock gate in the parent.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int IDLE_CNT_W  = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int RST_CLK_ON  = 1,
    parameter int GATE_CNT_W  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  auto_gate_en_i,
    input  logic                  force_on_i,
    input  logic [IDLE_CNT_W-1:0] idle_thr_i,
    input  logic                  busy_i,
    input  logic                  req_i,
    output logic                  ack_o,
    output logic                  clk_en_o,
    output logic [1:0]            state_o,
    output logic [GATE_CNT_W-1:0] gate_cnt_o
);

    // Wake counter only needs to reach WAKE_CYCLES-1.
    localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [WAKE_W-1:0] WAKE_LAST =
        WAKE_W'((WAKE_CYCLES > 0) ? (WAKE_CYCLES - 1) : 0);
    localparam cgc_state_e RST_STATE = (RST_CLK_ON != 0) ? ON : OFF;
    localparam logic       RST_EN    = (RST_CLK_ON != 0);

    cgc_state_e            state_q, state_nxt;
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_nxt;
    logic [IDLE_CNT_W-1:0] thr_q, thr_nxt;
    logic [WAKE_W-1:0]     wake_cnt_q, wake_cnt_nxt;
    logic [GATE_CNT_W-1:0] gate_cnt_q, gate_cnt_nxt;
    logic                  wake;

    // Any reason to keep or bring back the clock.
    assign wake = req_i | busy_i | force_on_i | ~auto_gate_en_i;

    // Next-state and counter update logic.
    always_comb begin
        state_nxt    = state_q;
        idle_cnt_nxt = idle_cnt_q;
        thr_nxt      = thr_q;
        wake_cnt_nxt = wake_cnt_q;
        gate_cnt_nxt = gate_cnt_q;
        case (state_q)
            OFF: begin
                wake_cnt_nxt = '0;
                if (wake) begin
                    state_nxt = (WAKE_CYCLES == 0) ? ON : WAKE;
                end
            end
            WAKE: begin
                // Settling always runs to completion, even if wake drops.
                if (wake_cnt_q == WAKE_LAST) begin
                    state_nxt    = ON;
                    wake_cnt_nxt = '0;
                end else begin
                    wake_cnt_nxt = wake_cnt_q + 1'b1;
                end
            end
            ON: begin
                if (!wake) begin
                    state_nxt    = IDLE;
                    idle_cnt_nxt = '0;
                    // Threshold is frozen for the whole idle episode.
                    thr_nxt      = idle_thr_i;
                end
            end
            IDLE: begin
                // Wake has priority over a threshold hit in the same cycle.
                if (wake) begin
                    state_nxt = ON;
                end else if (idle_cnt_q == thr_q) begin
                    state_nxt = OFF;
                    if (gate_cnt_q != '1) begin
                        gate_cnt_nxt = gate_cnt_q + 1'b1;
                    end
                end else begin
                    idle_cnt_nxt = idle_cnt_q + 1'b1;
                end
            end
            default: state_nxt = RST_STATE;
        endcase
    end

    // State, counters and next-state-derived registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RST_STATE;
            idle_cnt_q <= '0;
            thr_q      <= '0;
            wake_cnt_q <= '0;
            gate_cnt_q <= '0;
            clk_en_o   <= RST_EN;
            ack_o      <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            idle_cnt_q <= idle_cnt_nxt;
            thr_q      <= thr_nxt;
            wake_cnt_q <= wake_cnt_nxt;
            gate_cnt_q <= gate_cnt_nxt;
            clk_en_o   <= cgc_clocked(state_nxt);
            ack_o      <= req_i & (state_nxt == ON);
        end
    end

    assign state_o    = state_q;
    assign gate_cnt_o = gate_cnt_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl (WAKE_CYCLES=2, reset into ON, 2-bit
// gate counter so saturation is reachable quickly).
module tb_clk_gate_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       auto_gate_en_i;
    logic       force_on_i;
    logic [7:0] idle_thr_i;
    logic       busy_i;
    logic       req_i;
    logic       ack_o;
    logic       clk_en_o;
    logic [1:0] state_o;
    logic [1:0] gate_cnt_o;

    int checks   = 0;
    int failures = 0;

    localparam int S_OFF = 0, S_WAKE = 1, S_ON = 2, S_IDLE = 3;

    clk_gate_ctrl #(
        .IDLE_CNT_W (8),
        .WAKE_CYCLES(2),
        .RST_CLK_ON (1),
        .GATE_CNT_W (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .auto_gate_en_i(auto_gate_en_i),
        .force_on_i    (force_on_i),
        .idle_thr_i    (idle_thr_i),
        .busy_i        (busy_i),
        .req_i         (req_i),
        .ack_o         (ack_o),
        .clk_en_o      (clk_en_o),
        .state_o       (state_o),
        .gate_cnt_o    (gate_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input int st, input int en);
        chk({tag, "_state"}, int'(state_o), st);
        chk({tag, "_clken"}, int'(clk_en_o), en);
    endtask

    initial begin
        rst_i = 1'b1; auto_gate_en_i = 1'b1; force_on_i = 1'b0;
        idle_thr_i = 8'd3; busy_i = 1'b0; req_i = 1'b0;

        // 1: reset into ON, then idle-gate with thr=3
        tick();
        chk_st("rst", S_ON, 1);
        chk("rst_ack", int'(ack_o), 0);
        chk("rst_gcnt", int'(gate_cnt_o), 0);
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_st("t1_idle", S_IDLE, 1);
        end
        tick();
        chk_st("t1_off", S_OFF, 0);
        chk("t1_gcnt", int'(gate_cnt_o), 1);

        // 2: request from OFF
        req_i = 1'b1;
        tick(); chk_st("t2_w0", S_WAKE, 1); chk("t2_ack0", int'(ack_o), 0);
        tick(); chk_st("t2_w1", S_WAKE, 1); chk("t2_ack1", int'(ack_o), 0);
        tick(); chk_st("t2_on", S_ON, 1);   chk("t2_ack2", int'(ack_o), 1);
        req_i = 1'b0;
        tick(); chk("t2_ackdrop", int'(ack_o), 0); chk_st("t2_idle", S_IDLE, 1);

        // 3: busy at idle count 2 returns to ON; count restarts afterwards
        tick(); tick();
        chk_st("t3_cnt2", S_IDLE, 1);
        busy_i = 1'b1;
        tick(); chk_st("t3_busy_on", S_ON, 1);
        busy_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_st("t3_restart", S_IDLE, 1);
        end
        tick(); chk_st("t3_off", S_OFF, 0);
        chk("t3_gcnt", int'(gate_cnt_o), 2);

        // 4a: thr=0 gates on the first IDLE cycle
        idle_thr_i = 8'd0;
        force_on_i = 1'b1;
        tick(); tick(); tick();
        chk_st("t4_on", S_ON, 1);
        force_on_i = 1'b0;
        tick(); chk_st("t4_idle", S_IDLE, 1);
        tick(); chk_st("t4_off", S_OFF, 0);
        chk("t4_gcnt", int'(gate_cnt_o), 3);

        // 4b: threshold change mid-episode is ignored
        idle_thr_i = 8'd10;
        force_on_i = 1'b1;
        tick(); tick(); tick();
        chk_st("t4b_on", S_ON, 1);
        force_on_i = 1'b0;
        tick(); chk_st("t4b_idle0", S_IDLE, 1);
        idle_thr_i = 8'd1;
        for (int i = 0; i < 10; i++) tick();
        chk_st("t4b_idle10", S_IDLE, 1);
        tick(); chk_st("t4b_off", S_OFF, 0);
        chk("t4b_gsat", int'(gate_cnt_o), 3);

        // 5a: wake coincides with threshold hit -> stays clocked
        idle_thr_i = 8'd2;
        force_on_i = 1'b1;
        tick(); tick(); tick();
        force_on_i = 1'b0;
        tick(); tick(); tick();
        chk_st("t5_hit", S_IDLE, 1);
        busy_i = 1'b1;
        tick(); chk_st("t5_wakewins", S_ON, 1);
        busy_i = 1'b0;
        tick(); tick(); tick(); tick();
        chk_st("t5_off", S_OFF, 0);

        // 5b: auto gating disabled wakes and holds the clock
        auto_gate_en_i = 1'b0;
        tick(); chk_st("t5_auto_w", S_WAKE, 1);
        tick(); tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_st("t5_hold", S_ON, 1);
        end
        auto_gate_en_i = 1'b1;

        // 6a: reset mid-WAKE
        idle_thr_i = 8'd0;
        tick(); tick();
        chk_st("t6_off", S_OFF, 0);
        req_i = 1'b1;
        tick(); chk_st("t6_wake", S_WAKE, 1);
        rst_i = 1'b1;
        tick(); chk_st("t6_rstw", S_ON, 1);
        chk("t6_rstw_ack", int'(ack_o), 0);
        chk("t6_rstw_gcnt", int'(gate_cnt_o), 0);
        rst_i = 1'b0; req_i = 1'b0;

        // 6b: reset mid-IDLE, then idle counter starts clean
        idle_thr_i = 8'd5;
        tick(); tick();
        chk_st("t6_midle", S_IDLE, 1);
        rst_i = 1'b1;
        tick(); chk_st("t6_rsti", S_ON, 1);
        rst_i = 1'b0;
        idle_thr_i = 8'd1;
        tick(); tick();
        chk_st("t6_i1", S_IDLE, 1);
        tick(); chk_st("t6_off2", S_OFF, 0);
        chk("t6_gcnt", int'(gate_cnt_o), 1);

        // busy pulse in OFF wakes without ack; then req in ON acks in 1 cycle
        busy_i = 1'b1;
        tick(); chk_st("bp_wake", S_WAKE, 1); chk("bp_ack0", int'(ack_o), 0);
        busy_i = 1'b0;
        tick(); tick(); chk_st("bp_on", S_ON, 1); chk("bp_ack1", int'(ack_o), 0);
        req_i = 1'b1;
        tick(); chk("on_ack", int'(ack_o), 1); chk_st("on_hold", S_ON, 1);
        req_i = 1'b0;
        tick(); chk("on_ackdrop", int'(ack_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
